adc_spi_sampler: RTL and testbench
==================================

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 8: SCLK half-period in clk cycles; legal range 4..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16: minimum clk cycles adc_cs_n stays high between frames; legal range 1..65535.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port enable, input, 1: 1 = run back-to-back conversions.
REQ-006 Port channel, input, 4: requested ADC channel; 0..7 are valid.
REQ-007 Port adc_cs_n, output, 1: ADC chip select, active-low.
REQ-008 Port adc_sclk, output, 1: SPI clock; idles low.
REQ-009 Port adc_mosi, output, 1: command bits to the ADC.
REQ-010 Port adc_miso, input, 1: result bits from the ADC; asynchronous to clk.
REQ-011 Port new_sample, output, 1: one-cycle strobe marking sample and sample_channel valid.
REQ-012 Port sample, output, 10: last conversion result, unsigned.
REQ-013 Port sample_channel, output, 4: channel of the last conversion result.
REQ-014 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-016 IDLE -> SETUP SHALL occur when enable=1 and channel<=7, with channel latched into chan_q on that edge; if channel>7, the block SHALL stay in IDLE and issue no frame.
REQ-017 SETUP SHALL last CLK_DIV cycles, with adc_cs_n=0, adc_sclk=0 and adc_mosi=1 (start bit).
REQ-018 SHIFT SHALL issue exactly 17 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high, indexed 0..16.
REQ-019 MOSI bit order SHALL be: index 0 = start (1), 1 = SGL (1), 2..4 = chan_q[2:0] MSB first, 5..16 = 0.
- Bit k is driven from SETUP entry for k=0, otherwise on the falling SCLK edge ending period k-1.
REQ-020 adc_miso SHALL pass through a 2-flop synchronizer.
- The synchronized value is captured on the clk edge where SCLK goes high->low.
- Indices 7..16 shift into a 10-bit register as B9..B0, MSB first; indices 0..6 are ignored.
REQ-021 HOLD SHALL last CLK_DIV cycles with adc_cs_n=0 and adc_sclk=0.
- On its final cycle: sample <= shift register, sample_channel <= chan_q, new_sample=1 for exactly one cycle.
REQ-022 adc_cs_n SHALL rise on the cycle after the new_sample strobe and stay high for GAP_CYCLES cycles (state GAP), then the state SHALL return to IDLE.
REQ-023 Channel changes while busy=1 SHALL NOT affect the current frame; the new value applies at the next IDLE->SETUP.
REQ-024 enable deasserted mid-frame SHALL let the frame complete, including new_sample; no further frame starts.
REQ-025 sample and sample_channel SHALL hold their values between strobes.
REQ-026 With enable held high, the frame period SHALL be CLK_DIV*(1+34+1) + GAP_CYCLES + 2 clk cycles (1 IDLE, 1 strobe-to-cs overhead) — 306 cycles at defaults.
REQ-027 adc_sclk, adc_cs_n and adc_mosi SHALL be driven directly from flops.

Reset
REQ-028 While rst=0, the outputs SHALL be: adc_cs_n=1, adc_sclk=0, adc_mosi=0, new_sample=0, sample=0, sample_channel=0, busy=0; state=IDLE; synchronizer and counters cleared.
REQ-029 Reset asserted mid-frame SHALL immediately raise adc_cs_n and SHALL NOT produce a new_sample strobe.
REQ-030 After rst deasserts, the first frame SHALL start no earlier than the second clk edge.

Verification
REQ-031 ADC model returns 0x2A5 on channel 3; enable=1, channel=3 -> MOSI bits 1,1,0,1,1 then zeros, sample=0x2A5, sample_channel=3, one-cycle new_sample.
REQ-032 Two frames back-to-back at defaults -> new_sample strobes exactly 306 cycles apart, with adc_cs_n high for at least 16 cycles between frames.
REQ-033 channel switched 5->2 at SHIFT index 3 -> current frame encodes 5 and reports sample_channel=5; next frame encodes 2.
REQ-034 channel=9 with enable=1 -> adc_cs_n stays 1, busy=0, no strobe for 1000 cycles.
REQ-035 rst pulsed low at SHIFT index 10 -> adc_cs_n=1 within the same cycle, no strobe, sample stays 0; normal frame resumes after release.
REQ-036 CLK_DIV=4, ADC returns 0x3FF then 0x000 -> both results exact, with an SCLK half-period of 4 cycles measured.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: SPI master for an MCP3008-style 10-bit ADC.
// It runs back-to-back single-ended conversions on a latched channel and strobes each result.
module adc_spi_sampler #(
   parameter int CLK_DIV    = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [3:0] channel,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   output logic       adc_mosi,
   input  logic       adc_miso,
   output logic       new_sample,
   output logic [9:0] sample,
   output logic [3:0] sample_channel,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  idx_q, idx_d;
   logic [2:0]  chan_q, chan_d;
   logic [9:0]  sh_q, sh_d, sample_d;
   logic [3:0]  sample_channel_d;
   logic [1:0]  sync_q;
   logic        cs_n_d, sclk_d, mosi_d, new_sample_d, rdy_q, half_done;

   function automatic logic mosi_bit(input logic [4:0] k, input logic [2:0] c);
      return k < 5'd2 ? 1'b1 : k == 5'd2 ? c[2] : k == 5'd3 ? c[1] : k == 5'd4 ? c[0] : 1'b0;
   endfunction

   assign half_done = cnt_q == 16'(CLK_DIV - 1);
   assign busy      = state_q != IDLE;

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q + 16'd1;
      idx_d            = idx_q;
      chan_d           = chan_q;
      sh_d             = sh_q;
      sample_d         = sample;
      sample_channel_d = sample_channel;
      cs_n_d           = adc_cs_n;
      sclk_d           = adc_sclk;
      mosi_d           = adc_mosi;
      new_sample_d     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable && rdy_q && channel <= 4'd7) begin
               state_d = SETUP;
               chan_d  = channel[2:0];
               idx_d   = '0;
               cs_n_d  = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = 1'b1;
            end
         end
         SETUP: if (half_done) begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: if (half_done) begin
            cnt_d  = '0;
            sclk_d = ~adc_sclk;
            // falling SCLK edge: capture MISO, advance to the next bit
            if (adc_sclk) begin
               idx_d  = idx_q + 5'd1;
               mosi_d = mosi_bit(idx_q + 5'd1, chan_q);
               if (idx_q >= 5'd7) sh_d = {sh_q[8:0], sync_q[1]};
               if (idx_q == 5'd16) state_d = HOLD;
            end
         end
         HOLD: if (half_done) begin
            state_d          = GAP;
            cnt_d            = '0;
            sample_d         = sh_q;
            sample_channel_d = {1'b0, chan_q};
            new_sample_d     = 1'b1;
         end
         GAP: begin
            // first GAP cycle carries the strobe with cs still low
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
            if (cnt_q == 16'(GAP_CYCLES)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         idx_q          <= '0;
         chan_q         <= '0;
         sh_q           <= '0;
         sync_q         <= '0;
         rdy_q          <= 1'b0;
         adc_cs_n       <= 1'b1;
         adc_sclk       <= 1'b0;
         adc_mosi       <= 1'b0;
         new_sample     <= 1'b0;
         sample         <= '0;
         sample_channel <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         chan_q         <= chan_d;
         sh_q           <= sh_d;
         sync_q         <= {sync_q[0], adc_miso};
         rdy_q          <= 1'b1;
         adc_cs_n       <= cs_n_d;
         adc_sclk       <= sclk_d;
         adc_mosi       <= mosi_d;
         new_sample     <= new_sample_d;
         sample         <= sample_d;
         sample_channel <= sample_channel_d;
      end
   end
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: scoreboard bench with a behavioural ADC per DUT instance.
// Instance a uses the defaults; instance b runs CLK_DIV=4, GAP_CYCLES=4.
module tb_adc_spi_sampler;
   typedef struct packed {
      logic [9:0]  s;
      logic [3:0]  c;
      logic [16:0] cmd;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1;
   logic enable_a = 1'b0, enable_b = 1'b0;
   logic [3:0] channel_a = '0, channel_b = '0;
   logic miso_a = 1'b0, miso_b = 1'b0;
   logic cs_n_a, sclk_a, mosi_a, ns_a, busy_a, cs_n_b, sclk_b, mosi_b, ns_b, busy_b;
   logic [9:0] sample_a, sample_b;
   logic [3:0] sch_a, sch_b;

   exp_t q_a[$], q_b[$];
   exp_t e_a, e_b;
   int checks = 0, failures = 0, n_a = 0, n_b = 0, cyc = 0;
   int st_a[$], st_b[$];
   logic [9:0] val_a = '0, val_b = '0;
   logic [16:0] cmd_a = '0, cmd_b = '0;
   int k_a = 0, k_b = 0, hi_run = 0, last_hi = 0, hp_a = 0, hp_b = 0;
   time rise_a = 0, rise_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;

   adc_spi_sampler dut_a (
      .clk(clk), .rst(rst), .enable(enable_a), .channel(channel_a),
      .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .adc_mosi(mosi_a), .adc_miso(miso_a),
      .new_sample(ns_a), .sample(sample_a), .sample_channel(sch_a), .busy(busy_a)
   );

   adc_spi_sampler #(.CLK_DIV(4), .GAP_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .enable(enable_b), .channel(channel_b),
      .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_mosi(mosi_b), .adc_miso(miso_b),
      .new_sample(ns_b), .sample(sample_b), .sample_channel(sch_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [9:0] s, input logic [2:0] c);
      return {s, {1'b0, c}, {2'b11, c, 12'd0}};
   endfunction

   // ADC models: record command bits and present result bits at each SCLK rise
   always @(negedge cs_n_a) k_a = 0;
   always @(negedge cs_n_b) k_b = 0;
   always @(posedge sclk_a) begin
      rise_a = $time;
      if (k_a < 17) cmd_a[16-k_a] = mosi_a;
      miso_a = (k_a >= 7 && k_a <= 16) ? val_a[16-k_a] : 1'b0;
      k_a++;
   end
   always @(posedge sclk_b) begin
      rise_b = $time;
      if (k_b < 17) cmd_b[16-k_b] = mosi_b;
      miso_b = (k_b >= 7 && k_b <= 16) ? val_b[16-k_b] : 1'b0;
      k_b++;
   end
   always @(negedge sclk_a) hp_a = int'(($time - rise_a) / 10);
   always @(negedge sclk_b) hp_b = int'(($time - rise_b) / 10);

   always @(negedge clk) begin
      if (prev_a) chk("strobe_width_a", ns_a, 0);
      if (prev_b) chk("strobe_width_b", ns_b, 0);
      if (ns_a) begin
         n_a++;
         st_a.push_back(cyc);
         if (q_a.size() == 0) chk("strobe_unexpected_a", 1, 0);
         else begin
            e_a = q_a.pop_front();
            chk("sample_a", sample_a, e_a.s);
            chk("sample_channel_a", sch_a, e_a.c);
            chk("mosi_cmd_a", cmd_a, e_a.cmd);
         end
      end
      if (ns_b) begin
         n_b++;
         st_b.push_back(cyc);
         if (q_b.size() == 0) chk("strobe_unexpected_b", 1, 0);
         else begin
            e_b = q_b.pop_front();
            chk("sample_b", sample_b, e_b.s);
            chk("sample_channel_b", sch_b, e_b.c);
            chk("mosi_cmd_b", cmd_b, e_b.cmd);
         end
      end
      prev_a = ns_a;
      prev_b = ns_b;
      if (cs_n_a) hi_run++;
      else if (hi_run > 0) begin
         last_hi = hi_run;
         hi_run  = 0;
      end
   end

   task automatic wait_n(input bit b, input int n);
      int i = 0;
      while ((b ? n_b : n_a) < n && i < 2000) begin
         @(posedge clk);
         i++;
      end
      chk(b ? "wait_strobe_b" : "wait_strobe_a", (b ? n_b : n_a) >= n, 1);
   endtask

   task automatic wait_k(input int t);
      int i = 0;
      while (k_a != t && i < 2000) begin
         @(posedge clk);
         i++;
      end
      chk("wait_sclk_index", k_a, t);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy_a && i < 2000) begin
         @(posedge clk);
         i++;
      end
      chk("wait_idle_a", busy_a, 0);
   endtask

   initial begin
      int bad, n0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", cs_n_a, 1);
      chk("rst_sclk", sclk_a, 0);
      chk("rst_mosi", mosi_a, 0);
      chk("rst_new_sample", ns_a, 0);
      chk("rst_sample", sample_a, 0);
      chk("rst_sample_channel", sch_a, 0);
      chk("rst_busy", busy_a, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // channel 3, two back-to-back frames
      val_a = 10'h2A5;
      channel_a = 4'd3;
      q_a.push_back(mk(10'h2A5, 3'd3));
      q_a.push_back(mk(10'h2A5, 3'd3));
      enable_a = 1'b1;
      wait_n(0, 2);
      enable_a = 1'b0;
      chk("frame_period_a", st_a[1] - st_a[0], 306);
      chk("cs_high_gap_a", last_hi, 17);
      chk("sclk_half_a", hp_a, 8);
      wait_idle();

      // channel change mid-frame applies to the next frame only
      val_a = 10'h155;
      channel_a = 4'd5;
      q_a.push_back(mk(10'h155, 3'd5));
      q_a.push_back(mk(10'h155, 3'd2));
      enable_a = 1'b1;
      wait_k(4);
      channel_a = 4'd2;
      wait_n(0, 4);
      enable_a = 1'b0;
      wait_idle();
      repeat (20) @(posedge clk);
      #1;
      chk("sample_hold", sample_a, 10'h155);
      chk("sample_channel_hold", sch_a, 2);

      // invalid channel never starts a frame
      channel_a = 4'd9;
      enable_a = 1'b1;
      n0 = n_a;
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (!cs_n_a || busy_a) bad++;
      end
      chk("ch9_active_cycles", bad, 0);
      chk("ch9_strobes", n_a - n0, 0);
      enable_a = 1'b0;

      // reset mid-SHIFT aborts the frame
      val_a = 10'h0F0;
      channel_a = 4'd1;
      enable_a = 1'b1;
      wait_k(11);
      #1 rst = 1'b0;
      #1;
      chk("abort_cs_n", cs_n_a, 1);
      chk("abort_busy", busy_a, 0);
      chk("abort_sclk", sclk_a, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_sample", sample_a, 0);
      chk("abort_sample_channel", sch_a, 0);
      chk("abort_strobes", n_a, 4);
      rst = 1'b1;
      q_a.push_back(mk(10'h0F0, 3'd1));
      @(posedge clk);
      #1;
      chk("no_start_first_edge", cs_n_a, 1);
      wait_n(0, 5);
      enable_a = 1'b0;
      wait_idle();

      // CLK_DIV=4 instance, full-scale then zero
      val_b = 10'h3FF;
      channel_b = 4'd6;
      q_b.push_back(mk(10'h3FF, 3'd6));
      q_b.push_back(mk(10'h000, 3'd6));
      enable_b = 1'b1;
      wait_n(1, 1);
      val_b = 10'h000;
      wait_n(1, 2);
      enable_b = 1'b0;
      chk("sclk_half_b", hp_b, 4);
      chk("frame_period_b", st_b[1] - st_b[0], 150);
      repeat (10) @(posedge clk);
      chk("queue_left_a", q_a.size(), 0);
      chk("queue_left_b", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
